// File: rtl/gpio_slave_ctrl.sv
// gpio_slave_ctrl: memory-mapped GPIO port with direction/output control,
// synchronized input view and edge-triggered W1C interrupt status.
`default_nettype none

module gpio_slave_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [5:0] c_SEL_MODER = 6'h00;
  localparam logic [5:0] c_SEL_IDR   = 6'h01;
  localparam logic [5:0] c_SEL_ODR   = 6'h02;
  localparam logic [5:0] c_SEL_EDGE  = 6'h03;
  localparam logic [5:0] c_SEL_IER   = 6'h04;
  localparam logic [5:0] c_SEL_ISR   = 6'h05;

  localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]                  r_moder;
  logic [WIDTH-1:0]                  r_odr;
  logic [WIDTH-1:0]                  r_edge;
  logic [WIDTH-1:0]                  r_ier;
  logic [WIDTH-1:0]                  r_isr;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [c_ARM_W-1:0]                r_arm_cnt;

  logic             w_wr;
  logic [5:0]       w_sel;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_sync;
  logic             w_armed;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd_val;
  logic             w_unused;

  assign w_wr     = cs & we;
  assign w_sel    = addr[7:2];
  assign w_wdat   = wdata[WIDTH-1:0];
  assign w_unused = ^{addr[1:0], wdata};

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_armed = (r_arm_cnt == c_ARM_LAST);
  assign w_rise  = w_sync & ~r_prev;
  assign w_fall  = ~w_sync & r_prev;
  // Output pins and the post-reset fill window never raise status.
  assign w_event = ((r_edge & w_fall) | (~r_edge & w_rise)) & ~r_moder & {WIDTH{w_armed}};
  assign w_clr   = (w_wr && (w_sel == c_SEL_ISR)) ? w_wdat : '0;

  assign gpio_oe  = r_moder;
  assign gpio_out = r_odr & r_moder;
  assign irq      = |(r_isr & r_ier);

  always_comb begin
    w_rd_val = '0;
    if (cs) begin
      case (w_sel)
        c_SEL_MODER: w_rd_val = r_moder;
        c_SEL_IDR:   w_rd_val = w_sync;
        c_SEL_ODR:   w_rd_val = r_odr;
        c_SEL_EDGE:  w_rd_val = r_edge;
        c_SEL_IER:   w_rd_val = r_ier;
        c_SEL_ISR:   w_rd_val = r_isr;
        default:     w_rd_val = '0;
      endcase
    end
    rdata              = '0;
    rdata[WIDTH-1:0]   = w_rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_moder   <= '0;
      r_odr     <= '0;
      r_edge    <= '0;
      r_ier     <= '0;
      r_isr     <= '0;
      r_sync    <= '0;
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
      r_prev <= w_sync;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
      end
      // A same-cycle set beats the W1C clear.
      r_isr <= (r_isr & ~w_clr) | w_event;
      if (w_wr) begin
        case (w_sel)
          c_SEL_MODER: r_moder <= w_wdat;
          c_SEL_ODR:   r_odr   <= w_wdat;
          c_SEL_EDGE:  r_edge  <= w_wdat;
          c_SEL_IER:   r_ier   <= w_wdat;
          default:     ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
